// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the uart block
// State encodings for the RX/TX FSMs and default parameter values.
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int DEF_DBITS      = 8;
  localparam int DEF_SB_TICK    = 16;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int TIMER_WIDTH    = 11;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - first-word-fall-through FIFO with full/empty flags
// Head is presented combinationally and forced to zero while empty.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] w_data_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] r_data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW-1:0]    w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d, w_succ, r_succ;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_wr, do_rd;

  // A write into a full FIFO is allowed when a read frees the slot the same cycle.
  assign do_rd  = rd_i & ~empty_q;
  assign do_wr  = wr_i & (~full_q | do_rd);
  assign w_succ = w_ptr_q + AW'(1);
  assign r_succ = r_ptr_q + AW'(1);

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[w_ptr_q] <= w_data_i;
  end

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    case ({do_wr, do_rd})
      2'b10: begin
        w_ptr_d = w_succ;
        empty_d = 1'b0;
        full_d  = (w_succ == r_ptr_q);
      end
      2'b01: begin
        r_ptr_d = r_succ;
        full_d  = 1'b0;
        empty_d = (r_succ == w_ptr_q);
      end
      2'b11: begin
        w_ptr_d = w_succ;
        r_ptr_d = r_succ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign r_data_o = empty_q ? '0 : mem_q[r_ptr_q];
  assign full_o   = full_q;
  assign empty_o  = empty_q;

endmodule

// File: rtl/uart.sv
// rtl/uart.sv - full-duplex UART with shared baud tick and per-direction FIFOs
// Receiver oversamples by sb_tick; transmitter shifts LSB first.
module uart
  import uart_pkg::*;
#(
  parameter int dbits      = DEF_DBITS,
  parameter int sb_tick    = DEF_SB_TICK,
  parameter int addr_width = DEF_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TIMER_WIDTH-1:0] TIMER_FINAL_VALUE,
  input  logic                   rx,
  input  logic                   rd_uart,
  output logic                   rx_empty,
  output logic [dbits-1:0]       r_data,
  input  logic                   wr_uart,
  input  logic [dbits-1:0]       w_data,
  output logic                   tx_full,
  output logic                   tx
);

  localparam int SW = $clog2(sb_tick);
  localparam int NW = $clog2(dbits);
  localparam logic [SW-1:0] S_LAST = SW'(sb_tick - 1);
  localparam logic [SW-1:0] S_MID  = SW'(sb_tick / 2 - 1);
  localparam logic [NW-1:0] N_LAST = NW'(dbits - 1);

  logic [TIMER_WIDTH-1:0] cnt_q, cnt_d;
  logic                   tick;
  logic                   rx_meta_q, rx_sync_q;

  logic [1:0]       rx_state_q, rx_state_d, tx_state_q, tx_state_d;
  logic [SW-1:0]    rx_s_q, rx_s_d, tx_s_q, tx_s_d;
  logic [NW-1:0]    rx_n_q, rx_n_d, tx_n_q, tx_n_d;
  logic [dbits-1:0] rx_b_q, rx_b_d, tx_b_q, tx_b_d, tx_head;
  logic             rx_done, rx_full, tx_empty, tx_pop, tx_bit, tx_q;

  // Compare with >= so a divisor lowered below the running count still wraps.
  assign tick  = (cnt_q == TIMER_FINAL_VALUE);
  assign cnt_d = (cnt_q >= TIMER_FINAL_VALUE) ? '0 : cnt_q + TIMER_WIDTH'(1);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_s_d     = rx_s_q;
    rx_n_d     = rx_n_q;
    rx_b_d     = rx_b_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      ST_IDLE: if (!rx_sync_q) begin
        rx_state_d = ST_START;
        rx_s_d     = '0;
      end
      ST_START: if (tick) begin
        if (rx_s_q == S_MID) begin
          rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
          rx_s_d     = '0;
          rx_n_d     = '0;
        end else rx_s_d = rx_s_q + SW'(1);
      end
      ST_DATA: if (tick) begin
        if (rx_s_q == S_LAST) begin
          rx_s_d = '0;
          rx_b_d = {rx_sync_q, rx_b_q[dbits-1:1]};
          if (rx_n_q == N_LAST) rx_state_d = ST_STOP;
          else rx_n_d = rx_n_q + NW'(1);
        end else rx_s_d = rx_s_q + SW'(1);
      end
      default: if (tick) begin
        if (rx_s_q == S_LAST) begin
          rx_done    = 1'b1;
          rx_state_d = ST_IDLE;
        end else rx_s_d = rx_s_q + SW'(1);
      end
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
    tx_pop     = 1'b0;
    tx_bit     = 1'b1;
    case (tx_state_q)
      ST_IDLE: if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_b_d     = tx_head;
        tx_s_d     = '0;
        tx_state_d = ST_START;
      end
      ST_START: begin
        tx_bit = 1'b0;
        if (tick) begin
          if (tx_s_q == S_LAST) begin
            tx_s_d     = '0;
            tx_n_d     = '0;
            tx_state_d = ST_DATA;
          end else tx_s_d = tx_s_q + SW'(1);
        end
      end
      ST_DATA: begin
        tx_bit = tx_b_q[0];
        if (tick) begin
          if (tx_s_q == S_LAST) begin
            tx_s_d = '0;
            tx_b_d = tx_b_q >> 1;
            if (tx_n_q == N_LAST) tx_state_d = ST_STOP;
            else tx_n_d = tx_n_q + NW'(1);
          end else tx_s_d = tx_s_q + SW'(1);
        end
      end
      default: if (tick) begin
        if (tx_s_q == S_LAST) tx_state_d = ST_IDLE;
        else tx_s_d = tx_s_q + SW'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_s_q     <= '0;
      rx_n_q     <= '0;
      rx_b_q     <= '0;
      tx_state_q <= ST_IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_s_q     <= rx_s_d;
      rx_n_q     <= rx_n_d;
      rx_b_q     <= rx_b_d;
      tx_state_q <= tx_state_d;
      tx_s_q     <= tx_s_d;
      tx_n_q     <= tx_n_d;
      tx_b_q     <= tx_b_d;
      tx_q       <= tx_bit;
    end
  end

  uart_fifo #(.WIDTH(dbits), .AW(addr_width)) u_rx_fifo (
    .clk_i    (clk),
    .reset_i  (reset),
    .wr_i     (rx_done & ~rx_full),
    .w_data_i (rx_b_q),
    .rd_i     (rd_uart),
    .r_data_o (r_data),
    .full_o   (rx_full),
    .empty_o  (rx_empty)
  );

  uart_fifo #(.WIDTH(dbits), .AW(addr_width)) u_tx_fifo (
    .clk_i    (clk),
    .reset_i  (reset),
    .wr_i     (wr_uart),
    .w_data_i (w_data),
    .rd_i     (tx_pop),
    .r_data_o (tx_head),
    .full_o   (tx_full),
    .empty_o  (tx_empty)
  );

  assign tx = tx_q;

endmodule

// File: tb/tb_uart.sv
// tb/tb_uart.sv - self-checking bench for uart using two cross-wired instances
// Instance A's receiver can be driven directly by the bench instead of B's tx.
module tb_uart;

  localparam int SB = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] tfv;
  logic        rd_a, wr_a, rd_b, wr_b;
  logic [7:0]  wd_a, wd_b, rdat_a, rdat_b;
  logic        rx_empty_a, tx_full_a, tx_a, rx_empty_b, tx_full_b, tx_b;
  logic        drive_rx, tb_rx, rx_a;

  int checks = 0;
  int errors = 0;

  assign rx_a = drive_rx ? tb_rx : tx_b;

  always #5 clk = ~clk;

  uart dut_a (
    .clk(clk), .reset(reset), .TIMER_FINAL_VALUE(tfv), .rx(rx_a),
    .rd_uart(rd_a), .rx_empty(rx_empty_a), .r_data(rdat_a),
    .wr_uart(wr_a), .w_data(wd_a), .tx_full(tx_full_a), .tx(tx_a)
  );

  uart dut_b (
    .clk(clk), .reset(reset), .TIMER_FINAL_VALUE(tfv), .rx(tx_a),
    .rd_uart(rd_b), .rx_empty(rx_empty_b), .r_data(rdat_b),
    .wr_uart(wr_b), .w_data(wd_b), .tx_full(tx_full_b), .tx(tx_b)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int bit_period();
    return SB * (int'(tfv) + 1);
  endfunction

  task automatic do_reset(input logic [10:0] v);
    tfv = v; reset = 1'b1;
    rd_a = 0; rd_b = 0; wr_a = 0; wr_b = 0; wd_a = 0; wd_b = 0;
    drive_rx = 1'b0; tb_rx = 1'b1;
    step(3);
    reset = 1'b0;
    step(2);
  endtask

  task automatic send_frame(input logic [7:0] b);
    int bp;
    bp = bit_period();
    tb_rx = 1'b0; step(bp);
    for (int i = 0; i < 8; i++) begin
      tb_rx = b[i]; step(bp);
    end
    tb_rx = 1'b1; step(bp);
  endtask

  task automatic wait_rx(input bit sel_b, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if ((sel_b ? rx_empty_b : rx_empty_a) == 1'b0) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset();
    do_reset(11'd4);
    checks += 8;
    if (tx_a !== 1'b1)       begin errors++; $display("FAIL reset_tx_a: got %b expected 1", tx_a); end
    if (tx_b !== 1'b1)       begin errors++; $display("FAIL reset_tx_b: got %b expected 1", tx_b); end
    if (rx_empty_a !== 1'b1) begin errors++; $display("FAIL reset_rx_empty_a: got %b expected 1", rx_empty_a); end
    if (rx_empty_b !== 1'b1) begin errors++; $display("FAIL reset_rx_empty_b: got %b expected 1", rx_empty_b); end
    if (tx_full_a !== 1'b0)  begin errors++; $display("FAIL reset_tx_full_a: got %b expected 0", tx_full_a); end
    if (tx_full_b !== 1'b0)  begin errors++; $display("FAIL reset_tx_full_b: got %b expected 0", tx_full_b); end
    if (rdat_a !== 8'h00)    begin errors++; $display("FAIL reset_r_data_a: got %h expected 00", rdat_a); end
    if (rdat_b !== 8'h00)    begin errors++; $display("FAIL reset_r_data_b: got %h expected 00", rdat_b); end
  endtask

  task automatic test_loopback();
    logic [7:0] x, y;
    bit ok_a, ok_b;
    do_reset(11'd4);
    x = 8'($urandom); y = 8'($urandom);
    wr_a = 1; wd_a = x; wr_b = 1; wd_b = y;
    step(1);
    wr_a = 0; wr_b = 0;
    wait_rx(1'b0, 30 * bit_period(), ok_a);
    wait_rx(1'b1, 30 * bit_period(), ok_b);
    checks += 2;
    if (!ok_a) begin errors++; $display("FAIL loop_timeout_a: got empty expected data"); end
    if (!ok_b) begin errors++; $display("FAIL loop_timeout_b: got empty expected data"); end
    step(2);
    checks += 2;
    if (rdat_a !== y) begin errors++; $display("FAIL loop_data_a: got %h expected %h", rdat_a, y); end
    if (rdat_b !== x) begin errors++; $display("FAIL loop_data_b: got %h expected %h", rdat_b, x); end
    rd_a = 1; rd_b = 1;
    step(1);
    rd_a = 0; rd_b = 0;
    checks += 4;
    if (rx_empty_a !== 1'b1) begin errors++; $display("FAIL loop_pop_empty_a: got %b expected 1", rx_empty_a); end
    if (rx_empty_b !== 1'b1) begin errors++; $display("FAIL loop_pop_empty_b: got %b expected 1", rx_empty_b); end
    if (rdat_a !== 8'h00)    begin errors++; $display("FAIL loop_pop_data_a: got %h expected 00", rdat_a); end
    if (rdat_b !== 8'h00)    begin errors++; $display("FAIL loop_pop_data_b: got %h expected 00", rdat_b); end
  endtask

  task automatic test_waveform();
    logic [7:0] vals [2];
    logic [7:0] b;
    do_reset(11'd1);
    vals[0] = 8'hA5; vals[1] = 8'($urandom);
    for (int v = 0; v < 2; v++) begin
      b = vals[v];
      checks++;
      if (tx_a !== 1'b1) begin errors++; $display("FAIL wave_idle_before: got %b expected 1", tx_a); end
      wr_a = 1; wd_a = b;
      step(1);
      wr_a = 0;
      checks++;
      if (tx_a !== 1'b1) begin errors++; $display("FAIL wave_latency_n: got %b expected 1", tx_a); end
      step(1);
      checks++;
      if (tx_a !== 1'b1) begin errors++; $display("FAIL wave_latency_n1: got %b expected 1", tx_a); end
      step(1);
      checks++;
      if (tx_a !== 1'b0) begin errors++; $display("FAIL wave_latency_n2: got %b expected 0", tx_a); end
      step(16);
      checks++;
      if (tx_a !== 1'b0) begin errors++; $display("FAIL wave_start: got %b expected 0", tx_a); end
      for (int k = 0; k < 8; k++) begin
        step(32);
        checks++;
        if (tx_a !== b[k]) begin errors++; $display("FAIL wave_bit%0d: got %b expected %b", k, tx_a, b[k]); end
      end
      step(32);
      checks++;
      if (tx_a !== 1'b1) begin errors++; $display("FAIL wave_stop: got %b expected 1", tx_a); end
      step(64);
      checks++;
      if (tx_a !== 1'b1) begin errors++; $display("FAIL wave_idle_after: got %b expected 1", tx_a); end
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp_q [$];
    logic [7:0] b, e;
    bit ok, stray;
    do_reset(11'd3);
    for (int k = 1; k <= 18; k++) begin
      b = 8'($urandom);
      wr_a = 1; wd_a = b;
      step(1);
      if (k <= 17) exp_q.push_back(b);
      checks++;
      if (tx_full_a !== (k >= 17)) begin
        errors++; $display("FAIL full_flag_w%0d: got %b expected %b", k, tx_full_a, (k >= 17));
      end
    end
    wr_a = 0;
    for (int i = 0; i < 17; i++) begin
      wait_rx(1'b1, 3 * 10 * bit_period(), ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL full_rx_timeout_%0d: got empty expected data", i); break; end
      e = exp_q.pop_front();
      checks++;
      if (rdat_b !== e) begin errors++; $display("FAIL full_rx_order_%0d: got %h expected %h", i, rdat_b, e); end
      rd_b = 1; step(1); rd_b = 0;
    end
    stray = 1'b0;
    for (int i = 0; i < 3 * 10 * bit_period(); i++) begin
      if (!rx_empty_b) stray = 1'b1;
      step(1);
    end
    checks++;
    if (stray !== 1'b0) begin errors++; $display("FAIL full_extra_byte: got %b expected 0", stray); end
  endtask

  task automatic test_false_start();
    logic [7:0] r;
    bit ok, seen;
    do_reset(11'd3);
    drive_rx = 1'b1;
    step(10);
    tb_rx = 1'b0;
    step(4 * (int'(tfv) + 1));
    tb_rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 * bit_period(); i++) begin
      if (!rx_empty_a) seen = 1'b1;
      step(1);
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL false_start_empty: got %b expected 0", seen); end
    for (int f = 0; f < 2; f++) begin
      r = (f == 0) ? 8'h5A : 8'($urandom);
      send_frame(r);
      wait_rx(1'b0, 2 * bit_period(), ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL false_rx_timeout_%0d: got empty expected data", f); end
      checks++;
      if (rdat_a !== r) begin errors++; $display("FAIL false_rx_data_%0d: got %h expected %h", f, rdat_a, r); end
      rd_a = 1; step(1); rd_a = 0;
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] c;
    bit ok;
    int bp;
    do_reset(11'd3);
    bp = bit_period();
    wr_a = 1; wd_a = 8'($urandom);
    step(1);
    wr_a = 0;
    step(2);
    step(4 * bp + bp / 2);
    reset = 1'b1;
    step(1);
    checks += 4;
    if (tx_a !== 1'b1)       begin errors++; $display("FAIL mid_reset_tx: got %b expected 1", tx_a); end
    if (tx_full_a !== 1'b0)  begin errors++; $display("FAIL mid_reset_tx_full: got %b expected 0", tx_full_a); end
    if (rx_empty_a !== 1'b1) begin errors++; $display("FAIL mid_reset_rx_empty_a: got %b expected 1", rx_empty_a); end
    if (rx_empty_b !== 1'b1) begin errors++; $display("FAIL mid_reset_rx_empty_b: got %b expected 1", rx_empty_b); end
    reset = 1'b0;
    step(2);
    c = 8'($urandom);
    wr_a = 1; wd_a = c;
    step(1);
    wr_a = 0;
    wait_rx(1'b1, 3 * 10 * bp, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL mid_after_timeout: got empty expected data"); end
    if (rdat_b !== c) begin errors++; $display("FAIL mid_after_data: got %h expected %h", rdat_b, c); end
    rd_b = 1; step(1); rd_b = 0;
    checks++;
    if (rx_empty_b !== 1'b1) begin errors++; $display("FAIL mid_after_empty: got %b expected 1", rx_empty_b); end
  endtask

  task automatic test_rx_overflow();
    logic [7:0] exp_q [$];
    logic [7:0] b, e;
    do_reset(11'd3);
    drive_rx = 1'b1;
    step(5);
    for (int f = 0; f < 17; f++) begin
      b = 8'($urandom);
      if (f < 16) exp_q.push_back(b);
      send_frame(b);
    end
    step(bit_period());
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      checks += 2;
      if (rx_empty_a !== 1'b0) begin errors++; $display("FAIL ovf_empty_%0d: got %b expected 0", i, rx_empty_a); end
      if (rdat_a !== e) begin errors++; $display("FAIL ovf_data_%0d: got %h expected %h", i, rdat_a, e); end
      rd_a = 1; step(1); rd_a = 0;
    end
    checks += 2;
    if (rx_empty_a !== 1'b1) begin errors++; $display("FAIL ovf_final_empty: got %b expected 1", rx_empty_a); end
    if (rdat_a !== 8'h00)    begin errors++; $display("FAIL ovf_final_data: got %h expected 00", rdat_a); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_waveform();
    test_fifo_full();
    test_false_start();
    test_reset_midframe();
    test_rx_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
